// File: rtl/hazard_detection_unit.sv
// -----------------------------------------------------------------------------
// hazard_detection_unit
//
// Sits beside the decode stage of the five-stage pipeline. It remembers what
// was issued into EX (valid, destination, load, register write). From that it
// decides each cycle whether the instruction in ID can issue (RUN), must wait
// one cycle for a load result (STALL), or is on a wrong path behind a taken
// branch (FLUSH). A saturating counter records stall/flush cycles for
// performance debug.
//
// Ports
//   clk             system clock, all state updates on the rising edge
//   reset           asynchronous, active-high, clears all state immediately
//   id_Rn / id_Rm   source registers of the instruction in ID
//   id_uses_Rn/Rm   the ID instruction really reads that source
//   id_Rd           destination register of the instruction in ID
//   id_RegWrite     the ID instruction writes id_Rd
//   id_MemRead      the ID instruction is a load
//   ex_branch_taken the branch in EX resolved taken this cycle
//   pc_write        1 = PC may update
//   ifid_write      1 = IF/ID may load
//   ifid_flush      1 = IF/ID loads a NOP
//   idex_bubble     1 = ID/EX loads control zeros
//   load_pending    a valid load occupies EX
//   stall_count     saturating count of stall or flush cycles
// -----------------------------------------------------------------------------
module hazard_detection_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_Rn,
  input  logic [4:0]           id_Rm,
  input  logic                 id_uses_Rn,
  input  logic                 id_uses_Rm,
  input  logic [4:0]           id_Rd,
  input  logic                 id_RegWrite,
  input  logic                 id_MemRead,
  input  logic                 ex_branch_taken,
  output logic                 pc_write,
  output logic                 ifid_write,
  output logic                 ifid_flush,
  output logic                 idex_bubble,
  output logic                 load_pending,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    CTRL_RUN   = 2'd0,
    CTRL_STALL = 2'd1,
    CTRL_FLUSH = 2'd2
  } ctrl_e;

  localparam logic [4:0]           XZR     = 5'd31;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 ex_valid_q, ex_valid_d;
  logic [4:0]           ex_rd_q, ex_rd_d;
  logic                 ex_mem_read_q, ex_mem_read_d;
  logic                 ex_reg_write_q, ex_reg_write_d;
  logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

  logic  lu_s;
  ctrl_e ctrl_s;

  // Load-use detection: a real load in EX whose result the ID instruction reads.
  // XZR is a constant zero, so a "load" into it never produces a dependency.
  always_comb begin
    lu_s = 1'b0;
    if (ex_valid_q && ex_mem_read_q && ex_reg_write_q && (ex_rd_q != XZR)) begin
      lu_s = (id_uses_Rn && (id_Rn == ex_rd_q)) ||
             (id_uses_Rm && (id_Rm == ex_rd_q));
    end else begin
      lu_s = 1'b0;
    end
  end

  // Priority select: a taken branch discards the ID instruction, so it wins
  // over any load-use hazard that instruction would have had.
  always_comb begin
    ctrl_s = CTRL_RUN;
    if (ex_branch_taken) begin
      ctrl_s = CTRL_FLUSH;
    end else if (lu_s) begin
      ctrl_s = CTRL_STALL;
    end else begin
      ctrl_s = CTRL_RUN;
    end
  end

  // Pipeline control decode, zero-latency from the selected control state.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (ctrl_s)
      CTRL_FLUSH: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      CTRL_STALL: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b1;
      end
      CTRL_RUN: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
      end
      default: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
      end
    endcase
  end

  // Next EX-tracking state: a bubble leaves EX empty, otherwise ID issues.
  always_comb begin
    ex_valid_d     = 1'b0;
    ex_rd_d        = 5'd0;
    ex_mem_read_d  = 1'b0;
    ex_reg_write_d = 1'b0;
    if (idex_bubble) begin
      ex_valid_d     = 1'b0;
      ex_rd_d        = 5'd0;
      ex_mem_read_d  = 1'b0;
      ex_reg_write_d = 1'b0;
    end else begin
      ex_valid_d     = 1'b1;
      ex_rd_d        = id_Rd;
      ex_mem_read_d  = id_MemRead;
      ex_reg_write_d = id_RegWrite;
    end
  end

  // Next counter value: count every bubble cycle (stall or flush), hold at max.
  always_comb begin
    stall_count_d = stall_count_q;
    if (idex_bubble && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_rd_q        <= 5'd0;
      ex_mem_read_q  <= 1'b0;
      ex_reg_write_q <= 1'b0;
      stall_count_q  <= {CNT_WIDTH{1'b0}};
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_rd_q        <= ex_rd_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_reg_write_q <= ex_reg_write_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign load_pending = ex_valid_q & ex_mem_read_q;
  assign stall_count  = stall_count_q;

endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Detects load-use and taken-branch hazards in the five-stage pipelined CPU and generates the stall/flush controls for PC, IF/ID and ID/EX. Sits beside decode: it observes the instruction in ID, tracks the destination of the instruction it issues into EX, and suppresses issue when the operand forwarding path cannot yet supply a load result. Maintains a saturating stall-cycle counter for performance debug.

## Interface

Parameters:
- CNT_WIDTH, 16, width of the stall/flush performance counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- id_Rn  input  5  first source register of the instruction in ID.
- id_Rm  input  5  second source register of the instruction in ID.
- id_uses_Rn  input  1  ID instruction reads Rn.
- id_uses_Rm  input  1  ID instruction reads Rm (R-type, STUR data, CBZ test).
- id_Rd  input  5  destination register of the instruction in ID.
- id_RegWrite  input  1  ID instruction writes Rd.
- id_MemRead  input  1  ID instruction is a load (LDUR).
- ex_branch_taken  input  1  branch in EX resolved taken this cycle.
- pc_write  output  1  1 = PC may update.
- ifid_write  output  1  1 = IF/ID register may load.
- ifid_flush  output  1  1 = IF/ID loads a NOP.
- idex_bubble  output  1  1 = ID/EX loads control zeros (bubble).
- load_pending  output  1  a valid load occupies EX.
- stall_count  output  CNT_WIDTH  saturating count of cycles with stall or flush.

## Operation

- Internal EX-tracking state: ex_valid, ex_Rd[4:0], ex_MemRead, ex_RegWrite.
- Each rising edge: if idex_bubble, ex_valid<=0, ex_MemRead<=0, ex_RegWrite<=0 (ex_Rd don't-care, held at 0); else capture ex_valid<=1, ex_Rd<=id_Rd, ex_MemRead<=id_MemRead, ex_RegWrite<=id_RegWrite.
- Load-use hazard (combinational): lu = ex_valid & ex_MemRead & ex_RegWrite & (ex_Rd != 31) & ((id_uses_Rn & id_Rn==ex_Rd) | (id_uses_Rm & id_Rm==ex_Rd)).
- Register 31 (XZR) never creates a hazard.
- Control states (combinational decode, priority order):
  - FLUSH (ex_branch_taken=1): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. Overrides lu; wrong-path dependent instruction is discarded.
  - STALL (lu=1, no branch): pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1.
  - RUN: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
- load_pending = ex_valid & ex_MemRead.
- stall_count increments by 1 on each edge where STALL or FLUSH was active; holds at all-ones (saturates, no wrap).
- Distance-2 and distance-3 dependencies are never stalled; forwarding from ALU/Mem results covers them.

## Timing

- Reset (async): ex_valid=0, ex_Rd=0, ex_MemRead=0, ex_RegWrite=0, stall_count=0; outputs immediately pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0 (unless ex_branch_taken=1), load_pending=0.
- Reset asserted mid-stall: stall deasserts in the same cycle without waiting for a clock edge.
- Control outputs are combinational from current inputs and EX-tracking state; zero-cycle latency.
- Load-use stall lasts exactly one cycle: the bubble clears ex_valid, so lu drops next cycle while ID still holds the same instruction, which then issues.
- Back-to-back loads with chained dependency (LDUR X1; LDUR X2,[X1]) stall once per dependency.
- stall_count updates one edge after the stalled/flushed cycle.

## Test plan

- Reset then RUN: reset=1 for 2 cycles, release; id_MemRead=0 → pc_write=1, idex_bubble=0, stall_count=0, load_pending=0.
- Load-use on Rn: cycle0 ID=LDUR X3 (id_Rd=3, MemRead=1, RegWrite=1); cycle1 ID=ADD X4,X3,X5 (Rn=3, uses both) → cycle1 pc_write=0, ifid_write=0, idex_bubble=1; cycle2 outputs RUN; stall_count=1.
- No hazard cases: load to X31 followed by reader of X31 → no stall; load X3 then instruction with id_uses_Rm=0 and Rm=3 → no stall; ALU (non-load) X3 then reader of X3 → no stall.
- Branch priority: load X3 in EX, dependent reader in ID, ex_branch_taken=1 same cycle → ifid_flush=1, idex_bubble=1, pc_write=1; next cycle load_pending=0, RUN.
- Async reset mid-stall: during STALL cycle assert reset between edges → pc_write returns to 1 and load_pending to 0 before next edge; stall_count=0.
- Counter saturation with CNT_WIDTH=4: force 20 consecutive flush cycles → stall_count stops at 15.
